ftq: RTL and testbench
======================

# ftq

Fetch target queue between the branch-prediction/fetch stage and the back end. The queue records one entry per fetch block: PC, predicted target, predicted direction and the return-address-stack pointer checkpoint. On a back-end mispredict or a pipeline flush, it truncates speculative entries, re-steers fetch and drives the RAS `recover` and `recover_ptr` inputs. Entries retire in order on commit.

## Interface
- DEPTH, 8: number of entries; must be a power of 2, at least 2. IDX_W = $clog2(DEPTH).
- RAS_DEPTH, 16: depth of the attached RAS. RP_W = $clog2(RAS_DEPTH)+1, which matches the RAS `ptr` width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- enq_valid  in  1  fetch presents a new block.
- enq_rdy  out  1  = !full && !redirect_valid && !flush.
- enq_pc  in  CPU_ADDR_BITS  fetch-block PC.
- enq_pred_target  in  CPU_ADDR_BITS  predicted next PC.
- enq_pred_taken  in  1  predicted direction.
- enq_ras_ptr  in  RP_W  RAS `ptr` after this block's own push/pop.
- enq_idx  out  IDX_W  slot the current enqueue will occupy (tail index); used as the tag.
- rd_idx  in  IDX_W  back-end lookup index.
- rd_pc, rd_pred_target  out  CPU_ADDR_BITS  combinational read of entry rd_idx.
- rd_pred_taken  out  1  combinational read of entry rd_idx.
- redirect_valid  in  1  mispredict reported for entry redirect_idx.
- redirect_idx  in  IDX_W  mispredicting entry; must be live.
- redirect_target  in  CPU_ADDR_BITS  correct next PC.
- flush  in  1  full pipeline flush (exception/trap).
- commit_en  in  1  retire the head entry.
- commit_rdy  out  1  = !empty.
- ras_recover  out  1  one-cycle pulse to RAS `recover`.
- ras_recover_ptr  out  RP_W  to RAS `recover_ptr`.
- fe_redirect_valid  out  1  one-cycle fetch re-steer pulse.
- fe_redirect_pc  out  CPU_ADDR_BITS  re-steer target.

## Operation
- Storage is a circular buffer. head and tail are IDX_W+1 bits (wrap bit).
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
  - count = tail - head, modulo 2^(IDX_W+1).
- Enqueue: on enq_valid && enq_rdy, write the entry at tail[IDX_W-1:0], then tail++.
- Commit: on commit_en && commit_rdy:
  - commit_ras_ptr <= entry[head].ras_ptr;
  - head++.
  - commit_en while empty is ignored.
- Redirect (no flush): tail <= {wrap-corrected} redirect_idx + 1.
  - The mispredicting entry stays live; all younger entries are discarded.
  - entry[redirect_idx].pred_target <= redirect_target.
  - Registered outputs next cycle: ras_recover=1, ras_recover_ptr=entry[redirect_idx].ras_ptr, fe_redirect_valid=1, fe_redirect_pc=redirect_target.
- Flush: head <= 0 and tail <= 0.
  - Registered outputs next cycle: ras_recover=1, ras_recover_ptr=commit_ras_ptr, fe_redirect_valid=0.
  - The trap PC is supplied elsewhere.
- Priority: flush > redirect > enqueue. enq_rdy is already low during redirect_valid or flush, so no enqueue occurs in those cycles.
- Commit in the same cycle as redirect: both apply (head++, tail truncates).
  - If redirect_idx == head, the queue becomes empty.
  - commit_ras_ptr updates normally.
- Commit in the same cycle as flush: the commit is dropped.
- Enqueue and commit in the same cycle: both apply and count is unchanged.
  - When full, enq_rdy=0. There is no bypass from commit.
- Reset values:
  - head=0, tail=0, commit_ras_ptr=0.
  - enq_rdy=1, commit_rdy=0, enq_idx=0.
  - ras_recover=0, ras_recover_ptr=0, fe_redirect_valid=0, fe_redirect_pc=0.
  - Entry contents are don't-care.
- Reset mid-operation: all live entries are lost and any pending recover/redirect pulse is cancelled immediately (asynchronous).

## Timing
- Enqueue: data is visible on the rd_* outputs one cycle after acceptance.
- rd_* are combinational from rd_idx, with no added latency.
- Recover and redirect pulses are registered: asserted for exactly one cycle, beginning the cycle after the redirect_valid/flush edge.
- Back-to-back redirects produce back-to-back pulses; the later one's pointer and target win.
- Pointer wrap: an index wraps DEPTH-1 → 0, toggling the wrap bit.
- Redirect truncation computes the new tail by placing redirect_idx+1 on the wrap side consistent with head:
  - wrap bit = head's wrap bit if redirect_idx >= head index, else the inverse.
  - If redirect_idx+1 == DEPTH, the index is 0 and the wrap bit toggles.

## Test plan
- Reset, then enqueue 3 blocks (PC 0x1000/0x2000/0x3000, ras_ptr 1/2/3) → enq_idx 0,1,2; commit_rdy=1; rd_idx=1 gives rd_pc=0x2000.
- Enqueue 8 (DEPTH) blocks → enq_rdy=0 after the 8th; enq_valid held 2 more cycles → no write. One commit → enq_rdy=1 next cycle.
- Enqueue 4 blocks (ras_ptr 1..4); redirect_idx=1, target 0x5000 → next cycle: ras_recover=1, ras_recover_ptr=2, fe_redirect_pc=0x5000 for one cycle. The next enq_idx is 2; rd_pred_target of entry 1 is 0x5000.
- Commit 2 entries (ras_ptr 1,2); enqueue 3 more; flush → next cycle: ras_recover=1, ras_recover_ptr=2, fe_redirect_valid=0, commit_rdy=0, enq_idx=0.
- Wrap case: commit 6, enqueue 6 so tail wraps past index 7. Redirect on index 0 → count = head..0 inclusive; ras_recover_ptr equals entry 0's checkpoint.
- Simultaneous commit + redirect on the head entry → queue empty next cycle, recover pulse with the head's ras_ptr. Assert rst_n low mid-pulse → ras_recover and fe_redirect_valid drop to 0 immediately.

Source files
------------

// File: rtl/ftq.sv
// Fetch target queue: one entry per fetch block (PC, predicted target/direction, RAS checkpoint),
// retired in order on commit, truncated on mispredict redirect or full flush.
module ftq #(
    parameter int DEPTH         = 8,
    parameter int RAS_DEPTH     = 16,
    parameter int CPU_ADDR_BITS = 32,
    localparam int IDX_W        = $clog2(DEPTH),
    localparam int RP_W         = $clog2(RAS_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     enq_valid,
    output logic                     enq_rdy,
    input  logic [CPU_ADDR_BITS-1:0] enq_pc,
    input  logic [CPU_ADDR_BITS-1:0] enq_pred_target,
    input  logic                     enq_pred_taken,
    input  logic [RP_W-1:0]          enq_ras_ptr,
    output logic [IDX_W-1:0]         enq_idx,

    input  logic [IDX_W-1:0]         rd_idx,
    output logic [CPU_ADDR_BITS-1:0] rd_pc,
    output logic [CPU_ADDR_BITS-1:0] rd_pred_target,
    output logic                     rd_pred_taken,

    input  logic                     redirect_valid,
    input  logic [IDX_W-1:0]         redirect_idx,
    input  logic [CPU_ADDR_BITS-1:0] redirect_target,
    input  logic                     flush,

    input  logic                     commit_en,
    output logic                     commit_rdy,

    output logic                     ras_recover,
    output logic [RP_W-1:0]          ras_recover_ptr,
    output logic                     fe_redirect_valid,
    output logic [CPU_ADDR_BITS-1:0] fe_redirect_pc
);

    localparam logic [IDX_W:0] PTR_ONE = 1;

    logic [CPU_ADDR_BITS-1:0] pc_mem     [DEPTH];
    logic [CPU_ADDR_BITS-1:0] target_mem [DEPTH];
    logic                     taken_mem  [DEPTH];
    logic [RP_W-1:0]          rasp_mem   [DEPTH];

    logic [IDX_W:0]  head;
    logic [IDX_W:0]  tail;
    logic [RP_W-1:0] commit_ras_ptr;

    logic            empty;
    logic            full;
    logic            do_enq;
    logic            do_commit;
    logic            do_redirect;
    logic            redir_wrap;
    logic [IDX_W:0]  redir_tail;

    assign empty = (head == tail);
    assign full  = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);

    assign enq_rdy    = !full && !redirect_valid && !flush;
    assign commit_rdy = !empty;
    assign enq_idx    = tail[IDX_W-1:0];

    assign do_enq      = enq_valid && enq_rdy;
    assign do_commit   = commit_en && !empty && !flush;
    assign do_redirect = redirect_valid && !flush;

    // The mispredicting entry sits at or after head in age order, so an index below head's
    // index lives on the opposite lap; the +1 carries into the wrap bit past DEPTH-1.
    always_comb begin
        redir_wrap = (redirect_idx >= head[IDX_W-1:0]) ? head[IDX_W] : ~head[IDX_W];
        redir_tail = {redir_wrap, redirect_idx} + PTR_ONE;
    end

    assign rd_pc          = pc_mem[rd_idx];
    assign rd_pred_target = target_mem[rd_idx];
    assign rd_pred_taken  = taken_mem[rd_idx];

    // Entry payload: not reset, only live slots are ever observed.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail[IDX_W-1:0]]     <= enq_pc;
            target_mem[tail[IDX_W-1:0]] <= enq_pred_target;
            taken_mem[tail[IDX_W-1:0]]  <= enq_pred_taken;
            rasp_mem[tail[IDX_W-1:0]]   <= enq_ras_ptr;
        end
        if (do_redirect) begin
            target_mem[redirect_idx] <= redirect_target;
        end
    end

    // Pointers, commit checkpoint and the registered recover/re-steer pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head              <= '0;
            tail              <= '0;
            commit_ras_ptr    <= '0;
            ras_recover       <= 1'b0;
            ras_recover_ptr   <= '0;
            fe_redirect_valid <= 1'b0;
            fe_redirect_pc    <= '0;
        end else begin
            ras_recover       <= flush || redirect_valid;
            fe_redirect_valid <= do_redirect;
            if (flush) begin
                head            <= '0;
                tail            <= '0;
                ras_recover_ptr <= commit_ras_ptr;
            end else begin
                if (do_commit) begin
                    head           <= head + PTR_ONE;
                    commit_ras_ptr <= rasp_mem[head[IDX_W-1:0]];
                end
                if (do_redirect) begin
                    tail            <= redir_tail;
                    ras_recover_ptr <= rasp_mem[redirect_idx];
                    fe_redirect_pc  <= redirect_target;
                end else if (do_enq) begin
                    tail <= tail + PTR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ftq.sv
// Bench for ftq: directed steps followed by random traffic, checked against a queue-based model
// that tracks live entries in age order plus the slot index of the oldest one.
module tb_ftq;

    localparam int DEPTH     = 8;
    localparam int RAS_DEPTH = 16;
    localparam int AW        = 32;
    localparam int IDX_W     = 3;
    localparam int RP_W      = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enq_valid;
    logic             enq_rdy;
    logic [AW-1:0]    enq_pc;
    logic [AW-1:0]    enq_pred_target;
    logic             enq_pred_taken;
    logic [RP_W-1:0]  enq_ras_ptr;
    logic [IDX_W-1:0] enq_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [AW-1:0]    rd_pc;
    logic [AW-1:0]    rd_pred_target;
    logic             rd_pred_taken;
    logic             redirect_valid;
    logic [IDX_W-1:0] redirect_idx;
    logic [AW-1:0]    redirect_target;
    logic             flush;
    logic             commit_en;
    logic             commit_rdy;
    logic             ras_recover;
    logic [RP_W-1:0]  ras_recover_ptr;
    logic             fe_redirect_valid;
    logic [AW-1:0]    fe_redirect_pc;

    always #5 clk = ~clk;

    ftq #(.DEPTH(DEPTH), .RAS_DEPTH(RAS_DEPTH), .CPU_ADDR_BITS(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_valid(enq_valid), .enq_rdy(enq_rdy), .enq_pc(enq_pc),
        .enq_pred_target(enq_pred_target), .enq_pred_taken(enq_pred_taken),
        .enq_ras_ptr(enq_ras_ptr), .enq_idx(enq_idx),
        .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_pred_target(rd_pred_target),
        .rd_pred_taken(rd_pred_taken),
        .redirect_valid(redirect_valid), .redirect_idx(redirect_idx),
        .redirect_target(redirect_target), .flush(flush),
        .commit_en(commit_en), .commit_rdy(commit_rdy),
        .ras_recover(ras_recover), .ras_recover_ptr(ras_recover_ptr),
        .fe_redirect_valid(fe_redirect_valid), .fe_redirect_pc(fe_redirect_pc)
    );

    typedef struct {
        logic [AW-1:0]   pc;
        logic [AW-1:0]   tgt;
        logic            tk;
        logic [RP_W-1:0] rp;
    } ent_t;

    ent_t            q[$];
    int              hslot;
    logic [RP_W-1:0] m_cptr;
    int              errors = 0;
    int              checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enq_valid = 0; enq_pc = '0; enq_pred_target = '0; enq_pred_taken = 0; enq_ras_ptr = '0;
        redirect_valid = 0; redirect_idx = '0; redirect_target = '0; flush = 0; commit_en = 0;
    endtask

    task automatic model_reset();
        q.delete();
        hslot  = 0;
        m_cptr = '0;
    endtask

    function automatic int pos_of(input int idx);
        return (idx - hslot + DEPTH) % DEPTH;
    endfunction

    // One clock: check combinational outputs before the edge, advance the model, check pulses after.
    task automatic cycle();
        logic            m_rdy, d_flush, d_redir, d_commit, d_enq;
        logic [RP_W-1:0] old_cptr, exp_rp;
        int              p;
        ent_t            e;
        #1;
        m_rdy = (q.size() < DEPTH) && !redirect_valid && !flush;
        chk("enq_rdy", enq_rdy, m_rdy);
        chk("enq_idx", enq_idx, 64'((hslot + q.size()) % DEPTH));
        chk("commit_rdy", commit_rdy, q.size() != 0);
        p = pos_of(rd_idx);
        if (p < q.size()) begin
            chk("rd_pc", rd_pc, q[p].pc);
            chk("rd_pred_target", rd_pred_target, q[p].tgt);
            chk("rd_pred_taken", rd_pred_taken, q[p].tk);
        end
        d_flush  = flush;
        d_redir  = redirect_valid && !flush;
        d_commit = commit_en && (q.size() > 0) && !flush;
        d_enq    = enq_valid && m_rdy;
        old_cptr = m_cptr;
        exp_rp   = '0;
        e.pc = enq_pc; e.tgt = enq_pred_target; e.tk = enq_pred_taken; e.rp = enq_ras_ptr;
        @(posedge clk);
        #1;
        if (d_flush) begin
            q.delete();
            hslot = 0;
        end else begin
            if (d_redir) begin
                ent_t r;
                p = pos_of(redirect_idx);
                while (q.size() > p + 1) q.delete(q.size() - 1);
                r = q[p];
                r.tgt = redirect_target;
                q[p] = r;
                exp_rp = r.rp;
            end
            if (d_commit) begin
                m_cptr = q[0].rp;
                q.delete(0);
                hslot = (hslot + 1) % DEPTH;
            end
            if (d_enq) q.push_back(e);
        end
        chk("ras_recover", ras_recover, d_flush || d_redir);
        chk("fe_redirect_valid", fe_redirect_valid, d_redir);
        if (d_flush) begin
            chk("recover_ptr_flush", ras_recover_ptr, old_cptr);
        end else if (d_redir) begin
            chk("recover_ptr_redirect", ras_recover_ptr, exp_rp);
            chk("fe_redirect_pc", fe_redirect_pc, redirect_target);
        end
    endtask

    task automatic enq(input logic [AW-1:0] pc, input logic [RP_W-1:0] rp);
        enq_valid = 1; enq_pc = pc; enq_pred_target = pc + 32'h40;
        enq_pred_taken = rp[0]; enq_ras_ptr = rp;
        cycle();
        enq_valid = 0;
    endtask

    task automatic do_flush();
        idle(); flush = 1; cycle(); idle(); cycle();
    endtask

    initial begin
        idle();
        rd_idx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enq_rdy", enq_rdy, 1);
        chk("rst_commit_rdy", commit_rdy, 0);
        chk("rst_enq_idx", enq_idx, 0);
        chk("rst_ras_recover", ras_recover, 0);
        chk("rst_recover_ptr", ras_recover_ptr, 0);
        chk("rst_fe_valid", fe_redirect_valid, 0);
        chk("rst_fe_pc", fe_redirect_pc, 0);
        rst_n = 1;

        // Three blocks, then look up entry 1.
        for (int i = 0; i < 3; i++) enq(32'h1000 * (i + 1), RP_W'(i + 1));
        rd_idx = 1;
        #1;
        chk("t1_rd_pc", rd_pc, 32'h2000);
        chk("t1_commit_rdy", commit_rdy, 1);
        cycle();
        do_flush();

        // Fill, hold enq_valid while full, then free one slot.
        for (int i = 0; i < DEPTH; i++) enq(32'h2000 + 32'h10 * i, RP_W'(i));
        chk("t2_full_rdy", enq_rdy, 0);
        enq_valid = 1; enq_pc = 32'hDEAD0000; enq_ras_ptr = 5'd31;
        cycle(); cycle();
        idle(); commit_en = 1; cycle(); idle();
        chk("t2_rdy_after_commit", enq_rdy, 1);
        cycle();
        do_flush();

        // Redirect on entry 1 of four.
        for (int i = 0; i < 4; i++) enq(32'h100 * (i + 1), RP_W'(i + 1));
        redirect_valid = 1; redirect_idx = 1; redirect_target = 32'h5000;
        cycle();
        chk("t3_recover_ptr", ras_recover_ptr, 2);
        chk("t3_fe_pc", fe_redirect_pc, 32'h5000);
        idle(); rd_idx = 1;
        cycle();
        chk("t3_pulse_end", ras_recover, 0);
        chk("t3_enq_idx", enq_idx, 2);
        chk("t3_new_target", rd_pred_target, 32'h5000);

        // Commit both survivors, enqueue three, flush.
        commit_en = 1; cycle(); cycle(); commit_en = 0;
        for (int i = 0; i < 3; i++) enq(32'h3000 + 32'h10 * i, RP_W'(7 + i));
        flush = 1;
        cycle();
        chk("t4_recover_ptr", ras_recover_ptr, 2);
        chk("t4_fe_valid", fe_redirect_valid, 0);
        idle();
        #1;
        chk("t4_commit_rdy", commit_rdy, 0);
        chk("t4_enq_idx", enq_idx, 0);
        cycle();

        // Wrap: head at 6, tail past 7, redirect on index 0.
        for (int i = 0; i < 7; i++) enq(32'hA000 + 32'h10 * i, RP_W'(10 + i));
        commit_en = 1; repeat (6) cycle(); commit_en = 0;
        for (int i = 0; i < 6; i++) enq(32'hB000 + 32'h10 * i, RP_W'(20 + i));
        redirect_valid = 1; redirect_idx = 0; redirect_target = 32'h7000;
        cycle();
        chk("t5_recover_ptr", ras_recover_ptr, 21);
        idle();
        cycle();
        chk("t5_enq_idx", enq_idx, 1);
        chk("t5_commit_rdy", commit_rdy, 1);

        // Commit and redirect on the head together, then reset during the pulse.
        redirect_valid = 1; redirect_idx = 6; redirect_target = 32'h8000; commit_en = 1;
        cycle();
        chk("t6_recover_ptr", ras_recover_ptr, 16);
        chk("t6_empty", commit_rdy, 0);
        idle();
        rst_n = 0;
        #1;
        chk("t6_rst_recover", ras_recover, 0);
        chk("t6_rst_fe_valid", fe_redirect_valid, 0);
        chk("t6_rst_ptr", ras_recover_ptr, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            enq_valid       = ($urandom_range(0, 3) != 0);
            enq_pc          = $urandom;
            enq_pred_target = $urandom;
            enq_pred_taken  = 1'($urandom_range(0, 1));
            enq_ras_ptr     = RP_W'($urandom);
            commit_en       = ($urandom_range(0, 1) == 0);
            if (q.size() > 0 && $urandom_range(0, 9) == 0) begin
                redirect_valid  = 1;
                redirect_idx    = IDX_W'((hslot + int'($urandom_range(0, q.size() - 1))) % DEPTH);
                redirect_target = $urandom;
            end
            flush  = ($urandom_range(0, 49) == 0);
            rd_idx = IDX_W'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
